alu_checker: RTL and testbench

Synthesizable self-checking monitor that sits on the result side of the `alu` block. Each accepted vector (`a`, `b`, `sel`, `out`) is compared against an internal golden model of the ALU operation set. The checker counts passes and failures, captures the first mismatching vector, and asserts `done` after a programmed number of vectors. It is the response-side counterpart to the ALU stimulus bench, so the ALU can be exercised in hardware or in long regressions without text-log inspection.

---
 rtl/alu_checker.sv | 250 +++++++++++++++++++++++++
 tb/tb_alu_checker.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_checker.sv
// -----------------------------------------------------------------------------
// alu_checker
// Response-side monitor for the alu block. Every accepted vector (a, b, sel,
// out) is checked against a golden model of the ALU operation set. The block
// counts matches and mismatches, captures the first mismatching vector, and
// raises done once NUM_VECTORS vectors have been checked.
//
// Parameters
//   WIDTH        operand width (result is WIDTH+1 bits)
//   CNT_W        width of the pass/fail counters
//   NUM_VECTORS  vectors to accept before done (1 .. 2^CNT_W-1)
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   clear           synchronous restart, same effect as reset
//   in_valid        vector present        in_ready   checker accepts a vector
//   a, b, sel, out  vector under check (ALU operands, select, observed result)
//   pass_count      saturating count of matching vectors
//   fail_count      saturating count of mismatching vectors
//   err_valid       sticky, first mismatch captured
//   err_a, err_b, err_sel, err_out, err_exp   first mismatch details
//   done            sticky, NUM_VECTORS vectors checked
//
// Pipeline: S1 registers the vector and its expected result, S2 registers
// the compare result, and the counters/capture update one edge later.
// -----------------------------------------------------------------------------
module alu_checker #(
  parameter int WIDTH       = 8,
  parameter int CNT_W       = 16,
  parameter int NUM_VECTORS = 40
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       sel,
  input  logic [WIDTH:0]   out,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] fail_count,
  output logic             err_valid,
  output logic [WIDTH-1:0] err_a,
  output logic [WIDTH-1:0] err_b,
  output logic [2:0]       err_sel,
  output logic [WIDTH:0]   err_out,
  output logic [WIDTH:0]   err_exp,
  output logic             done
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_VECTORS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  // Golden model of the ALU; operands are zero-extended to WIDTH+1 bits.
  function automatic logic [WIDTH:0] golden(input logic [WIDTH-1:0] fa,
                                            input logic [WIDTH-1:0] fb,
                                            input logic [2:0]       fsel);
    logic [WIDTH:0] r;
    case (fsel)
      3'b000:  r = {1'b0, fa} + {1'b0, fb};
      3'b001:  r = {1'b0, fa} - {1'b0, fb};
      3'b010:  r = {1'b0, fa & fb};
      3'b011:  r = {1'b0, fa | fb};
      3'b100:  r = {1'b0, fa ^ fb};
      3'b101:  r = {1'b0, ~fa};
      3'b110:  r = {fa, 1'b0};
      3'b111:  r = {2'b00, fa[WIDTH-1:1]};
      default: r = {(WIDTH+1){1'b0}};
    endcase
    return r;
  endfunction

  logic             accept_s;
  logic             match_s;
  logic [CNT_W-1:0] acc_cnt_r;
  logic             stop_r;

  logic             s1_valid_r;
  logic             s1_last_r;
  logic [WIDTH-1:0] s1_a_r;
  logic [WIDTH-1:0] s1_b_r;
  logic [2:0]       s1_sel_r;
  logic [WIDTH:0]   s1_out_r;
  logic [WIDTH:0]   s1_exp_r;

  logic             s2_valid_r;
  logic             s2_last_r;
  logic             s2_match_r;
  logic [WIDTH-1:0] s2_a_r;
  logic [WIDTH-1:0] s2_b_r;
  logic [2:0]       s2_sel_r;
  logic [WIDTH:0]   s2_out_r;
  logic [WIDTH:0]   s2_exp_r;

  logic [CNT_W-1:0] pass_cnt_r;
  logic [CNT_W-1:0] fail_cnt_r;
  logic             err_valid_r;
  logic [WIDTH-1:0] err_a_r;
  logic [WIDTH-1:0] err_b_r;
  logic [2:0]       err_sel_r;
  logic [WIDTH:0]   err_out_r;
  logic [WIDTH:0]   err_exp_r;
  logic             done_r;

  // Handshake and S1 compare, all derived from registered state.
  always_comb begin
    accept_s = 1'b0;
    match_s  = 1'b0;
    if (!done_r && !stop_r) begin
      accept_s = in_valid;
    end else begin
      accept_s = 1'b0;
    end
    match_s = (s1_out_r == s1_exp_r);
  end

  assign in_ready = ~done_r & ~stop_r;

  // S1: capture the accepted vector, its expected result and the accept count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_last_r  <= 1'b0;
      s1_a_r     <= {WIDTH{1'b0}};
      s1_b_r     <= {WIDTH{1'b0}};
      s1_sel_r   <= 3'b000;
      s1_out_r   <= {(WIDTH+1){1'b0}};
      s1_exp_r   <= {(WIDTH+1){1'b0}};
      acc_cnt_r  <= {CNT_W{1'b0}};
      stop_r     <= 1'b0;
    end else if (clear) begin
      s1_valid_r <= 1'b0;
      s1_last_r  <= 1'b0;
      s1_a_r     <= {WIDTH{1'b0}};
      s1_b_r     <= {WIDTH{1'b0}};
      s1_sel_r   <= 3'b000;
      s1_out_r   <= {(WIDTH+1){1'b0}};
      s1_exp_r   <= {(WIDTH+1){1'b0}};
      acc_cnt_r  <= {CNT_W{1'b0}};
      stop_r     <= 1'b0;
    end else begin
      s1_valid_r <= accept_s;
      if (accept_s) begin
        s1_a_r    <= a;
        s1_b_r    <= b;
        s1_sel_r  <= sel;
        s1_out_r  <= out;
        s1_exp_r  <= golden(a, b, sel);
        s1_last_r <= (acc_cnt_r == LAST_IDX);
        acc_cnt_r <= acc_cnt_r + CNT_ONE;
        // Stop intake the moment the final vector is taken; it still drains.
        if (acc_cnt_r == LAST_IDX) begin
          stop_r <= 1'b1;
        end
      end
    end
  end

  // S2: register the compare result alongside the vector details.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_r <= 1'b0;
      s2_last_r  <= 1'b0;
      s2_match_r <= 1'b0;
      s2_a_r     <= {WIDTH{1'b0}};
      s2_b_r     <= {WIDTH{1'b0}};
      s2_sel_r   <= 3'b000;
      s2_out_r   <= {(WIDTH+1){1'b0}};
      s2_exp_r   <= {(WIDTH+1){1'b0}};
    end else if (clear) begin
      s2_valid_r <= 1'b0;
      s2_last_r  <= 1'b0;
      s2_match_r <= 1'b0;
      s2_a_r     <= {WIDTH{1'b0}};
      s2_b_r     <= {WIDTH{1'b0}};
      s2_sel_r   <= 3'b000;
      s2_out_r   <= {(WIDTH+1){1'b0}};
      s2_exp_r   <= {(WIDTH+1){1'b0}};
    end else begin
      s2_valid_r <= s1_valid_r;
      s2_last_r  <= s1_valid_r & s1_last_r;
      s2_match_r <= match_s;
      s2_a_r     <= s1_a_r;
      s2_b_r     <= s1_b_r;
      s2_sel_r   <= s1_sel_r;
      s2_out_r   <= s1_out_r;
      s2_exp_r   <= s1_exp_r;
    end
  end

  // Result side: saturating counters, first-mismatch capture and done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_cnt_r  <= {CNT_W{1'b0}};
      fail_cnt_r  <= {CNT_W{1'b0}};
      err_valid_r <= 1'b0;
      err_a_r     <= {WIDTH{1'b0}};
      err_b_r     <= {WIDTH{1'b0}};
      err_sel_r   <= 3'b000;
      err_out_r   <= {(WIDTH+1){1'b0}};
      err_exp_r   <= {(WIDTH+1){1'b0}};
      done_r      <= 1'b0;
    end else if (clear) begin
      pass_cnt_r  <= {CNT_W{1'b0}};
      fail_cnt_r  <= {CNT_W{1'b0}};
      err_valid_r <= 1'b0;
      err_a_r     <= {WIDTH{1'b0}};
      err_b_r     <= {WIDTH{1'b0}};
      err_sel_r   <= 3'b000;
      err_out_r   <= {(WIDTH+1){1'b0}};
      err_exp_r   <= {(WIDTH+1){1'b0}};
      done_r      <= 1'b0;
    end else if (s2_valid_r) begin
      if (s2_match_r) begin
        if (pass_cnt_r != CNT_MAX) begin
          pass_cnt_r <= pass_cnt_r + CNT_ONE;
        end
      end else begin
        if (fail_cnt_r != CNT_MAX) begin
          fail_cnt_r <= fail_cnt_r + CNT_ONE;
        end
        // Only the first mismatch is kept; later ones leave it untouched.
        if (!err_valid_r) begin
          err_valid_r <= 1'b1;
          err_a_r     <= s2_a_r;
          err_b_r     <= s2_b_r;
          err_sel_r   <= s2_sel_r;
          err_out_r   <= s2_out_r;
          err_exp_r   <= s2_exp_r;
        end
      end
      if (s2_last_r) begin
        done_r <= 1'b1;
      end
    end
  end

  assign pass_count = pass_cnt_r;
  assign fail_count = fail_cnt_r;
  assign err_valid  = err_valid_r;
  assign err_a      = err_a_r;
  assign err_b      = err_b_r;
  assign err_sel    = err_sel_r;
  assign err_out    = err_out_r;
  assign err_exp    = err_exp_r;
  assign done       = done_r;

endmodule

// File: tb/tb_alu_checker.sv
// -----------------------------------------------------------------------------
// tb_alu_checker
// Three checker instances (NUM_VECTORS = 40, 4, 2) share one stimulus stream.
// A behavioural model tracks, per instance, how many vectors were taken and
// what the counters and first-mismatch capture must show afterwards.
// -----------------------------------------------------------------------------
module tb_alu_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] a = 8'd0;
  logic [7:0] b = 8'd0;
  logic [2:0] sel = 3'd0;
  logic [8:0] out = 9'd0;

  logic        rdy [3];
  logic [15:0] pc  [3];
  logic [15:0] fc  [3];
  logic        ev  [3];
  logic [7:0]  ea  [3];
  logic [7:0]  eb  [3];
  logic [2:0]  es  [3];
  logic [8:0]  eo  [3];
  logic [8:0]  ee  [3];
  logic        dn  [3];

  int tests = 0;
  int fails = 0;

  int m_lim [3] = '{40, 4, 2};
  int m_acc [3];
  int m_pass[3];
  int m_fail[3];
  bit m_errv[3];
  int m_ea[3], m_eb[3], m_es[3], m_eo[3], m_ee[3];

  always #5 clk = ~clk;

  alu_checker #(.WIDTH(8), .CNT_W(16), .NUM_VECTORS(40)) u0 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(rdy[0]),
    .a(a), .b(b), .sel(sel), .out(out), .pass_count(pc[0]), .fail_count(fc[0]),
    .err_valid(ev[0]), .err_a(ea[0]), .err_b(eb[0]), .err_sel(es[0]),
    .err_out(eo[0]), .err_exp(ee[0]), .done(dn[0]));

  alu_checker #(.WIDTH(8), .CNT_W(16), .NUM_VECTORS(4)) u1 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(rdy[1]),
    .a(a), .b(b), .sel(sel), .out(out), .pass_count(pc[1]), .fail_count(fc[1]),
    .err_valid(ev[1]), .err_a(ea[1]), .err_b(eb[1]), .err_sel(es[1]),
    .err_out(eo[1]), .err_exp(ee[1]), .done(dn[1]));

  alu_checker #(.WIDTH(8), .CNT_W(16), .NUM_VECTORS(2)) u2 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(rdy[2]),
    .a(a), .b(b), .sel(sel), .out(out), .pass_count(pc[2]), .fail_count(fc[2]),
    .err_valid(ev[2]), .err_a(ea[2]), .err_b(eb[2]), .err_sel(es[2]),
    .err_out(eo[2]), .err_exp(ee[2]), .done(dn[2]));

  // Reference ALU in plain integer arithmetic.
  function automatic int ref_alu(input int ra, input int rb, input int rs);
    case (rs)
      0:       return ra + rb;
      1:       return (ra - rb + 512) % 512;
      2:       return ra & rb;
      3:       return ra | rb;
      4:       return ra ^ rb;
      5:       return 255 - ra;
      6:       return ra * 2;
      7:       return ra / 2;
      default: return 0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_acc[i] = 0; m_pass[i] = 0; m_fail[i] = 0; m_errv[i] = 1'b0;
      m_ea[i] = 0; m_eb[i] = 0; m_es[i] = 0; m_eo[i] = 0; m_ee[i] = 0;
    end
  endtask

  // Present one vector for one edge; in_valid stays as driven afterwards.
  task automatic drive(input bit v, input int ta, input int tb_, input int ts, input int to);
    int e;
    @(negedge clk);
    in_valid = v; a = ta[7:0]; b = tb_[7:0]; sel = ts[2:0]; out = to[8:0];
    @(posedge clk);
    #1;
    if (v) begin
      e = ref_alu(ta, tb_, ts);
      for (int i = 0; i < 3; i++) begin
        if (m_acc[i] < m_lim[i]) begin
          m_acc[i]++;
          if (to == e) m_pass[i]++;
          else begin
            m_fail[i]++;
            if (!m_errv[i]) begin
              m_errv[i] = 1'b1;
              m_ea[i] = ta; m_eb[i] = tb_; m_es[i] = ts; m_eo[i] = to; m_ee[i] = e;
            end
          end
        end
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
    end
  endtask

  task automatic do_clear();
    @(negedge clk);
    in_valid = 1'b0;
    clear = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clear = 1'b0;
    model_reset();
  endtask

  // Compare every instance against the model; call only after a drain.
  task automatic check_all(input string tag);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_u%0d_pass", tag, i), 32'(pc[i]), 32'(m_pass[i]));
      chk($sformatf("%s_u%0d_fail", tag, i), 32'(fc[i]), 32'(m_fail[i]));
      chk($sformatf("%s_u%0d_errv", tag, i), 32'(ev[i]), 32'(m_errv[i]));
      chk($sformatf("%s_u%0d_done", tag, i), 32'(dn[i]), 32'(m_acc[i] == m_lim[i]));
      chk($sformatf("%s_u%0d_rdy", tag, i), 32'(rdy[i]), 32'(m_acc[i] < m_lim[i]));
      if (m_errv[i]) begin
        chk($sformatf("%s_u%0d_ea", tag, i), 32'(ea[i]), 32'(m_ea[i]));
        chk($sformatf("%s_u%0d_eb", tag, i), 32'(eb[i]), 32'(m_eb[i]));
        chk($sformatf("%s_u%0d_es", tag, i), 32'(es[i]), 32'(m_es[i]));
        chk($sformatf("%s_u%0d_eo", tag, i), 32'(eo[i]), 32'(m_eo[i]));
        chk($sformatf("%s_u%0d_ee", tag, i), 32'(ee[i]), 32'(m_ee[i]));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ra, rb, rs, e;
    model_reset();

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    check_all("reset");
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset_u%0d_ea", i), 32'(ea[i]), 32'd0);
      chk($sformatf("reset_u%0d_eo", i), 32'(eo[i]), 32'd0);
    end

    // Four correct vectors a=200, b=100
    drive(1'b1, 200, 100, 0, 300);
    drive(1'b1, 200, 100, 1, 100);
    drive(1'b1, 200, 100, 2, 64);
    drive(1'b1, 200, 100, 3, 236);
    idle(2);
    check_all("basic");
    chk("basic_n4_pass", 32'(pc[1]), 32'd4);
    chk("basic_n4_fail", 32'(fc[1]), 32'd0);
    chk("basic_n4_errv", 32'(ev[1]), 32'd0);
    chk("basic_n4_done", 32'(dn[1]), 32'd1);
    chk("basic_n4_rdy",  32'(rdy[1]), 32'd0);

    // Boundary arithmetic
    do_clear();
    drive(1'b1, 0, 1, 1, 9'h1FF);
    drive(1'b1, 255, 255, 0, 510);
    drive(1'b1, 8'h81, 0, 7, 9'h040);
    idle(2);
    check_all("bound");
    chk("bound_pass", 32'(pc[0]), 32'd3);
    chk("bound_fail", 32'(fc[0]), 32'd0);

    // Injected errors; only the first mismatch is captured
    do_clear();
    drive(1'b1, 1, 2, 0, 3);
    drive(1'b1, 5, 3, 0, 9);
    drive(1'b1, 7, 1, 4, 0);
    drive(1'b1, 9, 4, 2, 0);
    idle(2);
    check_all("inject");
    chk("inject_fail", 32'(fc[0]), 32'd2);
    chk("inject_ea",   32'(ea[0]), 32'd5);
    chk("inject_eb",   32'(eb[0]), 32'd3);
    chk("inject_es",   32'(es[0]), 32'd0);
    chk("inject_eo",   32'(eo[0]), 32'd9);
    chk("inject_ee",   32'(ee[0]), 32'd8);
    chk("inject_ev",   32'(ev[0]), 32'd1);

    // Latency: visible only after the second edge following acceptance
    do_clear();
    drive(1'b1, 10, 20, 0, 30);
    @(negedge clk);
    in_valid = 1'b0;
    chk("lat_n0", 32'(pc[0]), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("lat_n1", 32'(pc[0]), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("lat_n2", 32'(pc[0]), 32'd1);

    // Clear while a vector sits in S1
    do_clear();
    drive(1'b1, 5, 3, 0, 9);
    do_clear();
    idle(2);
    check_all("clr_s1");
    chk("clr_s1_fail", 32'(fc[0]), 32'd0);
    chk("clr_s1_errv", 32'(ev[0]), 32'd0);

    // Clear colliding with an accept discards the vector
    @(negedge clk);
    clear = 1'b1; in_valid = 1'b1; a = 8'd5; b = 8'd3; sel = 3'd0; out = 9'd9;
    @(posedge clk);
    @(negedge clk);
    clear = 1'b0; in_valid = 1'b0;
    model_reset();
    idle(2);
    check_all("clr_col");

    // Asynchronous reset between edges
    drive(1'b1, 1, 1, 0, 2);
    drive(1'b1, 2, 2, 0, 4);
    drive(1'b1, 3, 3, 0, 6);
    idle(2);
    @(negedge clk);
    chk("arst_pre", 32'(pc[0]), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_pass", 32'(pc[0]), 32'd0);
    chk("arst_n2_done", 32'(dn[2]), 32'd0);
    chk("arst_n2_rdy", 32'(rdy[2]), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // in_valid 1-0-1 then extra pulses against NUM_VECTORS=2
    drive(1'b1, 4, 4, 2, 4);
    drive(1'b0, 9, 9, 0, 0);
    drive(1'b1, 6, 3, 3, 7);
    drive(1'b1, 8, 8, 4, 0);
    drive(1'b0, 1, 1, 0, 0);
    drive(1'b1, 8, 1, 6, 16);
    idle(3);
    check_all("toggle");
    chk("toggle_n2_pass", 32'(pc[2]), 32'd2);
    chk("toggle_n2_done", 32'(dn[2]), 32'd1);

    // Randomized stream with occasional corrupted results
    do_clear();
    for (int k = 0; k < 70; k++) begin
      ra = int'($urandom_range(0, 255));
      rb = int'($urandom_range(0, 255));
      rs = int'($urandom_range(0, 7));
      e  = ref_alu(ra, rb, rs);
      if ($urandom_range(0, 3) == 0) e = e ^ int'($urandom_range(1, 511));
      drive(($urandom_range(0, 3) != 0), ra, rb, rs, e);
    end
    idle(3);
    check_all("rand");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
